// File: rtl/inst_encoder_writer.sv
// ---------------------------------------------------------------------------
// inst_encoder_writer
//
// Turns field-level instruction descriptions (class, registers, funct fields,
// natural-form immediate) into RISC-V instruction words and writes them one
// word per cycle into an instruction memory. Only the opcode classes the main
// controller decodes are produced: R, lw, I, sw, jal, B and lui.
//
// Parameters:
//   ADDR_WIDTH - word-address width; memory depth is 2**ADDR_WIDTH words
//   BASE_ADDR  - byte address of the first word written (word-aligned)
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   start           - begin a new program (ignored while running)
//   in_valid/ready  - field-beat handshake; a beat transfers on valid & ready
//   in_class        - 0=R 1=lw 2=I 3=sw 4=jal 5=B 6=lui 7=illegal
//   rd, rs1, rs2    - register fields
//   funct3, funct7  - function fields (funct3: R/I/B, funct7: R only)
//   imm             - immediate in natural, unshuffled form
//   last            - final beat of the program
//   mem_we/addr/wdata - registered instruction-memory write port
//   count           - words written since the last start
//   busy, done      - running / finished status (never high together)
//   err             - sticky error flag, cleared by rst or an accepted start
// ---------------------------------------------------------------------------
module inst_encoder_writer #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_class,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  input  logic                  last,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CLS_R   = 3'd0;
  localparam logic [2:0] CLS_LW  = 3'd1;
  localparam logic [2:0] CLS_I   = 3'd2;
  localparam logic [2:0] CLS_SW  = 3'd3;
  localparam logic [2:0] CLS_JAL = 3'd4;
  localparam logic [2:0] CLS_B   = 3'd5;
  localparam logic [2:0] CLS_LUI = 3'd6;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // Memory capacity in words, one bit wider than count so the sum below
  // (committed words plus a write in flight) can never wrap.
  localparam logic [ADDR_WIDTH+1:0] MAX_WORDS = {2'b01, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  err_q, err_d;

  logic [31:0]           enc_word;
  logic                  enc_err;
  logic                  cls_illegal;
  logic                  fits_12;
  logic                  fits_13;
  logic                  fits_21;
  logic [ADDR_WIDTH+1:0] fill;
  logic                  full_pending;
  logic                  beat_fire;

  // An immediate fits an N-bit signed field when every bit from N-1 upward
  // is a copy of the sign bit.
  assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

  // count only advances once a write has actually happened, so the number
  // of words the memory will hold is count plus any write in flight. When
  // that reaches capacity no further beat may be taken.
  assign fill         = {1'b0, count_q} + {{(ADDR_WIDTH+1){1'b0}}, mem_we_q};
  assign full_pending = (fill == MAX_WORDS);

  assign in_ready  = (state_q == RUN) && !full_pending;
  assign beat_fire = in_valid && in_ready;

  // Combinational encoder: shuffles the natural immediate into each format.
  // jal/B drop imm[0]; out-of-range immediates are truncated but flagged.
  always_comb begin
    enc_word    = 32'h0;
    enc_err     = 1'b0;
    cls_illegal = 1'b0;
    case (in_class)
      CLS_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, OP_R};
      end
      CLS_LW: begin
        enc_word = {imm[11:0], rs1, 3'b010, rd, OP_LW};
        enc_err  = !fits_12;
      end
      CLS_I: begin
        enc_word = {imm[11:0], rs1, funct3, rd, OP_I};
        enc_err  = !fits_12;
      end
      CLS_SW: begin
        enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
        enc_err  = !fits_12;
      end
      CLS_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        enc_err  = imm[0] || !fits_21;
      end
      CLS_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
        enc_err  = imm[0] || !fits_13;
      end
      CLS_LUI: begin
        enc_word = {imm[31:12], rd, OP_LUI};
      end
      default: begin
        cls_illegal = 1'b1;
      end
    endcase
  end

  // Next-state logic. The write pointer and count advance in the cycle after
  // a write is presented, which keeps mem_addr showing the address actually
  // being written. A start overrides that advance because it rewinds both.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    err_d       = err_q;

    if (mem_we_q) begin
      mem_addr_d = mem_addr_q + 32'd4;
      count_d    = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          mem_addr_d = BASE_ADDR;
          count_d    = '0;
          err_d      = 1'b0;
        end
      end
      RUN: begin
        if (full_pending) begin
          // The in-flight write fills the memory: stop and flag overflow.
          state_d = DONE;
          err_d   = 1'b1;
        end else if (beat_fire) begin
          if (!cls_illegal) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = enc_word;
          end
          if (cls_illegal || enc_err) begin
            err_d = 1'b1;
          end
          if (last) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered write port. Reset drops any pending write at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 32'h0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign err       = err_q;
  // done waits for the final write to land; busy covers that same cycle.
  assign busy      = (state_q == RUN) || mem_we_q;
  assign done      = (state_q == DONE) && !mem_we_q;

endmodule

// File: tb/tb_inst_encoder_writer.sv
// ---------------------------------------------------------------------------
// tb_inst_encoder_writer
//
// Bench for inst_encoder_writer. A large instance (ADDR_WIDTH=10) runs the
// directed and random programs; a tiny instance (ADDR_WIDTH=2) sharing the
// same inputs exercises memory-full behaviour. Expected words come from an
// arithmetic reference encoder; expected addresses, counts, error flags and
// write cycles come from a per-program list model.
// ---------------------------------------------------------------------------
module tb_inst_encoder_writer;

  typedef struct {
    int          cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    bit          lst;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [2:0]  in_class;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        last;

  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] count;
  logic        busy;
  logic        done;
  logic        err;

  logic        s_in_ready;
  logic        s_mem_we;
  logic [31:0] s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_count;
  logic        s_busy;
  logic        s_done;
  logic        s_err;

  int check_count = 0;
  int error_count = 0;
  int cyc = 0;

  wr_t obs_q[$];
  wr_t obs_s[$];

  inst_encoder_writer #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .last(last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .busy(busy), .done(done), .err(err)
  );

  inst_encoder_writer #(.ADDR_WIDTH(2), .BASE_ADDR(32'h0)) dut_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_class(in_class), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .last(last), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .count(s_count), .busy(s_busy), .done(s_done), .err(s_err)
  );

  always #5 clk = ~clk;

  // Free-running cycle number, used to check write latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write presented by either instance, mid-cycle.
  always @(negedge clk) begin
    if (mem_we) obs_q.push_back('{mem_addr, mem_wdata, cyc});
    if (s_mem_we) obs_s.push_back('{s_mem_addr, s_mem_wdata, cyc});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference encoder built from masks and shifts on the natural immediate.
  function automatic logic [31:0] ref_encode(input beat_t b);
    logic [31:0] i;
    logic [31:0] w;
    i = b.imm;
    case (b.cls)
      0: w = (32'(b.f7) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
             | (32'(b.f3) << 12) | (32'(b.rd) << 7) | 32'h33;
      1: w = ((i & 32'hFFF) << 20) | (32'(b.rs1) << 15) | (32'd2 << 12)
             | (32'(b.rd) << 7) | 32'h03;
      2: w = ((i & 32'hFFF) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12)
             | (32'(b.rd) << 7) | 32'h13;
      3: w = (((i >> 5) & 32'h7F) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
             | (32'd2 << 12) | ((i & 32'h1F) << 7) | 32'h23;
      4: w = (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
             | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12)
             | (32'(b.rd) << 7) | 32'h6F;
      5: w = (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25)
             | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12)
             | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7) | 32'h63;
      6: w = (i & 32'hFFFFF000) | (32'(b.rd) << 7) | 32'h37;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Whether a legal-class beat should raise err (odd offset or out of range).
  function automatic bit ref_error(input beat_t b);
    int s;
    s = $signed(b.imm);
    case (b.cls)
      1, 2, 3: return (s < -2048) || (s > 2047);
      4:       return b.imm[0] || (s < -1048576) || (s > 1048575);
      5:       return b.imm[0] || (s < -4096) || (s > 4095);
      default: return 1'b0;
    endcase
  endfunction

  function automatic beat_t make_beat(input int cls, input int rdv, input int r1,
                                      input int r2, input int f3v, input int f7v,
                                      input logic [31:0] immv, input bit lst);
    beat_t b;
    b.cls = cls;
    b.rd  = 5'(rdv);
    b.rs1 = 5'(r1);
    b.rs2 = 5'(r2);
    b.f3  = 3'(f3v);
    b.f7  = 7'(f7v);
    b.imm = immv;
    b.lst = lst;
    return b;
  endfunction

  function automatic beat_t rand_beat(input bit lst, input bit legal_only);
    beat_t b;
    int    r;
    int    v;
    r = $urandom_range(0, 15);
    b.cls = (r == 15 && !legal_only) ? 7 : (r % 7);
    b.rd  = 5'($urandom);
    b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom);
    b.f3  = 3'($urandom);
    b.f7  = 7'($urandom);
    case ($urandom_range(0, 3))
      0: b.imm = $urandom;
      1: begin v = $urandom_range(0, 4095) - 2048; b.imm = v; end
      2: begin v = ($urandom_range(0, 8191) - 4096) & ~1; b.imm = v; end
      default: b.imm = $urandom & 32'hFFFFF000;
    endcase
    b.lst = lst;
    return b;
  endfunction

  task automatic drive_fields(input beat_t b);
    in_class = 3'(b.cls);
    rd       = b.rd;
    rs1      = b.rs1;
    rs2      = b.rs2;
    funct3   = b.f3;
    funct7   = b.f7;
    imm      = b.imm;
    last     = b.lst;
  endtask

  // Present one beat and hold it until accepted (bounded). Returns the cycle
  // number of the accepting edge. Called and returns at posedge + 1.
  task automatic applyStimulus(input beat_t b, input bit use_small, output int acc_cyc);
    int  waits;
    logic rdy;
    drive_fields(b);
    in_valid = 1'b1;
    waits    = 0;
    acc_cyc  = -1;
    forever begin
      @(negedge clk);
      rdy = use_small ? s_in_ready : in_ready;
      if (rdy) break;
      waits++;
      if (waits > 50) break;
    end
    if (!rdy) begin
      checkOutput("ready_timeout", {31'b0, rdy}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs_q.delete();
    obs_s.delete();
  endtask

  // Run a whole program on the large instance and compare every write, the
  // final count, err and status against the list model.
  task automatic run_program(input beat_t prog[$], input int gap_max);
    wr_t exp_q[$];
    int  k;
    bit  e;
    int  ac;
    int  g;
    int  n;
    bit  last_illegal;
    k = 0;
    e = 1'b0;
    obs_q.delete();
    pulse_start();
    foreach (prog[i]) begin
      g = $urandom_range(0, gap_max);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      applyStimulus(prog[i], 1'b0, ac);
      if (prog[i].cls == 7) begin
        e = 1'b1;
      end else begin
        exp_q.push_back('{32'h0 + 32'(4 * k), ref_encode(prog[i]), ac});
        k++;
        e = e | ref_error(prog[i]);
      end
    end
    last_illegal = (prog[prog.size() - 1].cls == 7);
    checkOutput("done_after_last", {31'b0, done}, {31'b0, last_illegal});
    checkOutput("busy_after_last", {31'b0, busy}, {31'b0, !last_illegal});
    n = 0;
    forever begin
      @(negedge clk);
      if (done || n > 20) break;
      n++;
    end
    checkOutput("prog_done", {31'b0, done}, 32'd1);
    checkOutput("prog_nwrites", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checkOutput("wr_addr", obs_q[i].addr, exp_q[i].addr);
      checkOutput("wr_data", obs_q[i].data, exp_q[i].data);
      checkOutput("wr_cycle", obs_q[i].cyc, exp_q[i].cyc);
    end
    checkOutput("prog_count", {21'b0, count}, k);
    checkOutput("prog_err", {31'b0, err}, {31'b0, e});
    checkOutput("prog_busy", {31'b0, busy}, 32'd0);
    checkOutput("prog_ready", {31'b0, in_ready}, 32'd0);
  endtask

  initial begin
    beat_t prog[$];
    beat_t b;
    int    ac;
    bit    saw;
    int    nb;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_class = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0; last = 1'b0;

    // Reset values, observed while rst is still held.
    #12;
    checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_count", {21'b0, count}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_ready", {31'b0, in_ready}, 32'd0);
    do_reset();

    // Single I beat: write appears one cycle after acceptance.
    $display("[TB] single I beat");
    pulse_start();
    applyStimulus(make_beat(2, 1, 0, 0, 0, 0, 32'd5, 1'b1), 1'b0, ac);
    checkOutput("i_mem_we", {31'b0, mem_we}, 32'd1);
    checkOutput("i_mem_addr", mem_addr, 32'h0);
    checkOutput("i_mem_wdata", mem_wdata, 32'h00500093);
    checkOutput("i_done_pending", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("i_count", {21'b0, count}, 32'd1);
    checkOutput("i_we_drop", {31'b0, mem_we}, 32'd0);
    checkOutput("i_done", {31'b0, done}, 32'd1);

    // Back-to-back program, restarted from DONE.
    $display("[TB] back-to-back program");
    prog.delete();
    prog.push_back(make_beat(0, 3, 1, 2, 0, 0, 32'd0, 1'b0));
    prog.push_back(make_beat(1, 4, 1, 0, 5, 0, 32'd4, 1'b0));
    prog.push_back(make_beat(3, 0, 1, 2, 0, 0, 32'd8, 1'b0));
    prog.push_back(make_beat(6, 5, 0, 0, 0, 0, 32'h12345000, 1'b1));
    run_program(prog, 0);
    if (obs_q.size() == 4) begin
      checkOutput("b2b_w0", obs_q[0].data, 32'h002081B3);
      checkOutput("b2b_w1", obs_q[1].data, 32'h0040A203);
      checkOutput("b2b_w2", obs_q[2].data, 32'h0020A423);
      checkOutput("b2b_w3", obs_q[3].data, 32'h123452B7);
    end

    // Branch/jump encodings, including an odd branch offset.
    $display("[TB] jal/B encodings");
    prog.delete();
    prog.push_back(make_beat(4, 1, 0, 0, 0, 0, 32'd8, 1'b0));
    prog.push_back(make_beat(5, 0, 1, 2, 0, 0, 32'd16, 1'b0));
    prog.push_back(make_beat(5, 0, 1, 2, 0, 0, 32'd17, 1'b1));
    run_program(prog, 1);
    if (obs_q.size() == 3) begin
      checkOutput("jal_word", obs_q[0].data, 32'h008000EF);
      checkOutput("b_word", obs_q[1].data, 32'h00208863);
      checkOutput("b_odd_word", obs_q[2].data, 32'h00208863);
    end
    checkOutput("b_odd_err", {31'b0, err}, 32'd1);

    // Beat held in IDLE is not taken until start, then written exactly once.
    $display("[TB] held beat across start");
    do_reset();
    b = make_beat(2, 2, 3, 0, 1, 0, 32'd7, 1'b0);
    drive_fields(b);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("held_ready_idle", {31'b0, in_ready}, 32'd0);
    checkOutput("held_no_write", obs_q.size(), 32'd0);
    pulse_start();
    @(negedge clk);
    checkOutput("held_ready_run", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("held_wdata", mem_wdata, ref_encode(b));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("held_once", obs_q.size(), 32'd1);
    checkOutput("held_count", {21'b0, count}, 32'd1);

    // Illegal class between two legal beats.
    $display("[TB] illegal class in stream");
    do_reset();
    prog.delete();
    prog.push_back(make_beat(2, 1, 0, 0, 0, 0, 32'd1, 1'b0));
    prog.push_back(make_beat(7, 1, 0, 0, 0, 0, 32'd1, 1'b0));
    prog.push_back(make_beat(2, 2, 0, 0, 0, 0, 32'd2, 1'b1));
    run_program(prog, 1);
    checkOutput("ill_err", {31'b0, err}, 32'd1);

    // Memory full on the small instance: four writes, fifth beat refused.
    $display("[TB] overflow on small memory");
    do_reset();
    prog.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      b = rand_beat(1'b0, 1'b1);
      b.imm = 32'd12;
      prog.push_back(b);
      applyStimulus(b, 1'b1, ac);
    end
    drive_fields(rand_beat(1'b0, 1'b1));
    in_valid = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (s_in_ready) saw = 1'b1;
    end
    in_valid = 1'b0;
    checkOutput("ovf_ready", {31'b0, saw}, 32'd0);
    checkOutput("ovf_nwrites", obs_s.size(), 32'd4);
    for (int i = 0; i < obs_s.size() && i < 4; i++) begin
      checkOutput("ovf_addr", obs_s[i].addr, 32'(4 * i));
      checkOutput("ovf_data", obs_s[i].data, ref_encode(prog[i]));
    end
    checkOutput("ovf_done", {31'b0, s_done}, 32'd1);
    checkOutput("ovf_err", {31'b0, s_err}, 32'd1);
    checkOutput("ovf_count", {29'b0, s_count}, 32'd4);
    checkOutput("ovf_busy", {31'b0, s_busy}, 32'd0);

    // Reset during a write drops it, then a restart begins at BASE_ADDR.
    $display("[TB] reset mid-write");
    do_reset();
    pulse_start();
    applyStimulus(make_beat(2, 3, 1, 0, 0, 0, 32'd9, 1'b0), 1'b0, ac);
    checkOutput("mid_we_before", {31'b0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_we_drop", {31'b0, mem_we}, 32'd0);
    checkOutput("mid_count", {21'b0, count}, 32'd0);
    checkOutput("mid_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("mid_busy", {31'b0, busy}, 32'd0);
    checkOutput("mid_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs_q.delete();
    prog.delete();
    prog.push_back(make_beat(6, 7, 0, 0, 0, 0, 32'hABCDE000, 1'b1));
    run_program(prog, 0);

    // Random programs, each restarted from DONE.
    $display("[TB] random programs");
    for (int p = 0; p < 30; p++) begin
      prog.delete();
      nb = $urandom_range(1, 12);
      for (int i = 0; i < nb; i++) prog.push_back(rand_beat(i == nb - 1, 1'b0));
      run_program(prog, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/inst_encoder_writer.md
Name: inst_encoder_writer

Overview:
Assembles RISC-V instruction words from field-level descriptions and writes them sequentially into instruction memory. It is the producing end of the opcode stream that the main controller decodes. It emits only the opcode classes that controller recognises: R, lw, I, sw, jal, B and lui. It sits between a program source (bench or boot path) and the instruction-memory write port, with a valid/ready input handshake and a registered write output.

Parameters:
ADDR_WIDTH, 10, word-address width; depth = 2^ADDR_WIDTH words
BASE_ADDR, 32'h0, byte address of the first written word; must be word-aligned

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a new program; ignored while in RUN
in_valid  input  1  a field beat is present
in_ready  output  1  the block accepts a beat this cycle
in_class  input  3  0=R, 1=lw, 2=I, 3=sw, 4=jal, 5=B, 6=lui, 7=illegal
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  used only by R, I and B
funct7  input  7  used only by R
imm  input  32  immediate, in natural (unshuffled) form
last  input  1  marks the final beat of the program
mem_we  output  1  instruction-memory write strobe
mem_addr  output  32  byte address of the word being written
mem_wdata  output  32  encoded instruction word
count  output  ADDR_WIDTH+1  number of words written since start
busy  output  1  high in RUN, or while a write is pending
done  output  1  level, high in DONE
err  output  1  sticky error flag; cleared by rst or by an accepted start

Behaviour:
- Clock and reset: one clock domain; rst is asynchronous, active-high.
- Reset values: state=IDLE; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; count=0; busy=0; done=0; err=0; in_ready=0.
- State machine has three states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - DONE --start--> RUN.
  - RUN --(accepted beat with last=1) or (count reaches 2^ADDR_WIDTH)--> DONE.
  - Entering RUN from start: next write address = BASE_ADDR, count=0, err=0.
- Handshake:
  - in_ready = 1 only in RUN with no transition to DONE pending.
  - A beat transfers when in_valid & in_ready.
  - The source holds all fields stable while in_valid=1 and in_ready=0.
- Write latency is 1 cycle. A beat accepted at edge N produces, for exactly one cycle after N, mem_we=1 with mem_addr and mem_wdata. After that write, mem_addr advances by 4 and count by 1.
- Back-to-back beats give back-to-back writes at one word per cycle.
- Encoding (opcode in bits 6:0):
  - R: {funct7, rs2, rs1, funct3, rd, 0110011}
  - lw: {imm[11:0], rs1, 010, rd, 0000011}; funct3 input is ignored.
  - I: {imm[11:0], rs1, funct3, rd, 0010011}
  - sw: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}
  - jal: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}
  - lui: {imm[31:12], rd, 0110111}
- Error conditions (each sets err; err stays set until cleared):
  - Illegal class (7): the beat is consumed, nothing is written, address and count do not advance.
  - jal/B with imm[0]=1: the word is still written, with imm[0] dropped.
  - Range violation: I/lw/sw imm outside -2048..2047; B outside ±4096; jal outside ±1M. The word is still written, truncated.
  - Overflow: after the write that makes count = 2^ADDR_WIDTH, the block enters DONE and sets err.
- last on an illegal beat still moves the block to DONE, with no write.
- done is high in DONE only after any pending write has completed. busy and done are never high together.
- start asserted in RUN is ignored. start in DONE restarts the program and clears err.
- rst mid-operation: a pending write is dropped (mem_we returns to 0 immediately), state returns to IDLE, and all outputs take their reset values.
- Sizing: combinational encode plus registered outputs; 120–250 lines of RTL expected.

Test Plan:
- Reset, start, then I beat (class 2, rd=1, rs1=0, funct3=0, imm=5) -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x00500093; count=1.
- Back-to-back, one per cycle:
  - R: rd=3, rs1=1, rs2=2, f3=0, f7=0
  - lw: rd=4, rs1=1, imm=4
  - sw: rs1=1, rs2=2, imm=8
  - lui: rd=5, imm=0x12345000, with last=1
  -> words 0x002081B3, 0x0040A203, 0x0020A423, 0x123452B7 at addresses 0, 4, 8, 12 on consecutive cycles; then done=1, count=4, err=0.
- Branch/jump encoding:
  - jal rd=1, imm=8 -> 0x008000EF
  - B rs1=1, rs2=2, f3=0, imm=16 -> 0x00208863
  - B with imm=17 -> err=1, word still 0x00208863
- in_valid held while in_ready=0 (IDLE before start) -> no write; after start the held beat is written exactly once.
- Class 7 beat between two legal beats -> err=1; only two writes, at addresses 0 and 4.
- Overflow with ADDR_WIDTH=2: five beats, none with last -> four writes (0–12), then DONE, err=1, in_ready=0, fifth beat not accepted.
- rst asserted in the same cycle mem_we=1 -> mem_we drops immediately, state IDLE, count=0; a following start restarts at BASE_ADDR.
